// File: rtl/fwd_hazard_if.sv
// Operand-forwarding / hazard bus between the pipeline (master) and fwd_hazard_unit (slave).
interface fwd_hazard_if #(
    parameter int NUM_RD = 2,
    parameter int REG_AW = 5
);
    logic [NUM_RD*REG_AW-1:0] rs_ID;
    logic [NUM_RD-1:0]        rs_used_ID;
    logic [REG_AW-1:0]        rd_ID;
    logic                     reg_WB_ID;
    logic                     long_issue;
    logic [REG_AW-1:0]        rd_MEM;
    logic [REG_AW-1:0]        rd_WB;
    logic                     reg_WB_MEM;
    logic                     reg_WB_WB;
    logic                     mem_read_MEM;
    logic                     flush;
    logic [NUM_RD*2-1:0]      forward_sel;
    logic                     stall;
    logic                     long_wb;
    logic [REG_AW-1:0]        long_rd;

    modport master (
        output rs_ID, rs_used_ID, rd_ID, reg_WB_ID, long_issue,
               rd_MEM, rd_WB, reg_WB_MEM, reg_WB_WB, mem_read_MEM, flush,
        input  forward_sel, stall, long_wb, long_rd
    );

    modport slave (
        input  rs_ID, rs_used_ID, rd_ID, reg_WB_ID, long_issue,
               rd_MEM, rd_WB, reg_WB_MEM, reg_WB_WB, mem_read_MEM, flush,
        output forward_sel, stall, long_wb, long_rd
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding, load-use and single-entry long-op scoreboard for the 5-stage pipeline.
// Optional FWD_STATS_EN adds a saturating stall-cycle counter on stall_cnt.
module fwd_hazard_unit #(
    parameter int NUM_RD   = 2,
    parameter int REG_AW   = 5,
    parameter int LONG_LAT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    fwd_hazard_if.slave  hz
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]  stall_cnt
`endif
);
    localparam int CW = $clog2(LONG_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } sb_state_e;

    sb_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] long_rd_q, long_rd_d;

    logic [NUM_RD*2-1:0] fwd_sel;
    logic [REG_AW-1:0]   rs;
    logic                used, mem_hit, wb_hit, long_hit;
    logic                load_use, raw, waw, structural;
    logic                busy, stall, accept;

    assign busy = (state_q == S_BUSY);

    always_comb begin
        fwd_sel  = '0;
        load_use = 1'b0;
        raw      = 1'b0;
        rs       = '0;
        used     = 1'b0;
        mem_hit  = 1'b0;
        wb_hit   = 1'b0;
        long_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rs       = hz.rs_ID[i*REG_AW +: REG_AW];
            used     = hz.rs_used_ID[i] && (rs != '0);
            mem_hit  = used && hz.reg_WB_MEM && (hz.rd_MEM == rs);
            wb_hit   = used && hz.reg_WB_WB && (hz.rd_WB == rs);
            long_hit = used && (long_rd_q == rs);
            // A load in MEM cannot forward; its select is irrelevant because the port stalls.
            if (mem_hit && hz.mem_read_MEM)
                load_use = 1'b1;
            if (mem_hit && !hz.mem_read_MEM)
                fwd_sel[i*2 +: 2] = 2'b01;
            else if (long_hit && (state_q == S_DONE))
                fwd_sel[i*2 +: 2] = 2'b11;
            else if (wb_hit)
                fwd_sel[i*2 +: 2] = 2'b10;
            if (long_hit && busy)
                raw = 1'b1;
        end
    end

    assign waw        = busy && hz.reg_WB_ID && (hz.rd_ID == long_rd_q) && (hz.rd_ID != '0);
    assign structural = busy && hz.long_issue;
    assign stall      = load_use | raw | waw | structural;
    assign accept     = hz.long_issue & ~stall & ~hz.flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        long_rd_d = long_rd_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    long_rd_d = hz.rd_ID;
                    if (LONG_LAT == 1) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CW'(LONG_LAT - 1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (hz.flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            long_rd_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            long_rd_q <= long_rd_d;
        end
    end

    assign hz.forward_sel = fwd_sel;
    assign hz.stall       = stall;
    assign hz.long_wb     = (state_q == S_DONE);
    assign hz.long_rd     = long_rd_q;

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit (NUM_RD=2, REG_AW=5, LONG_LAT=3).
module tb_fwd_hazard_unit;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    fwd_hazard_if #(.NUM_RD(2), .REG_AW(5)) hz ();

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt;
`endif

    fwd_hazard_unit #(
        .NUM_RD  (2),
        .REG_AW  (5),
        .LONG_LAT(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hz       (hz.slave)
`ifdef FWD_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_in();
        hz.rs_ID        = '0;
        hz.rs_used_ID   = '0;
        hz.rd_ID        = '0;
        hz.reg_WB_ID    = 1'b0;
        hz.long_issue   = 1'b0;
        hz.rd_MEM       = '0;
        hz.rd_WB        = '0;
        hz.reg_WB_MEM   = 1'b0;
        hz.reg_WB_WB    = 1'b0;
        hz.mem_read_MEM = 1'b0;
        hz.flush        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        clear_in();
        hz.long_issue = 1'b1;
        hz.rd_ID      = rd;
        hz.reg_WB_ID  = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clear_in();
        rst_n = 1'b0;
        hz.rs_ID      = {5'd5, 5'd5};
        hz.rs_used_ID = 2'b11;
        hz.rd_WB      = 5'd5;
        hz.reg_WB_WB  = 1'b1;
        #2;
        tests++;
        if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL reset_long_wb got %b want 0", hz.long_wb); end
        tests++;
        if (hz.long_rd !== 5'd0) begin fails++; $display("FAIL reset_long_rd got %0d want 0", hz.long_rd); end
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", hz.stall); end
        tests++;
        if (hz.forward_sel !== 4'b1010) begin fails++; $display("FAIL reset_fwd got %b want 1010", hz.forward_sel); end
`ifdef FWD_STATS_EN
        tests++;
        if (stall_cnt !== 32'd0) begin fails++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        clear_in();
    endtask

    task automatic test_forward();
        step();
        clear_in();
        hz.rs_ID      = {5'd5, 5'd5};
        hz.rs_used_ID = 2'b11;
        hz.rd_MEM     = 5'd5;
        hz.reg_WB_MEM = 1'b1;
        hz.rd_WB      = 5'd5;
        hz.reg_WB_WB  = 1'b1;
        #1;
        tests++;
        if (hz.forward_sel !== 4'b0101) begin fails++; $display("FAIL fwd_mem_prio got %b want 0101", hz.forward_sel); end
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL fwd_mem_stall got %b want 0", hz.stall); end
        hz.rd_MEM = 5'd0;
        #1;
        tests++;
        if (hz.forward_sel !== 4'b1010) begin fails++; $display("FAIL fwd_wb got %b want 1010", hz.forward_sel); end
        hz.rs_ID  = {5'd3, 5'd5};
        hz.rd_MEM = 5'd5;
        hz.rd_WB  = 5'd3;
        #1;
        tests++;
        if (hz.forward_sel !== 4'b1001) begin fails++; $display("FAIL fwd_mixed got %b want 1001", hz.forward_sel); end
        hz.rs_used_ID = 2'b00;
        #1;
        tests++;
        if (hz.forward_sel !== 4'b0000) begin fails++; $display("FAIL fwd_unused got %b want 0000", hz.forward_sel); end
        hz.rs_ID      = '0;
        hz.rs_used_ID = 2'b11;
        hz.rd_MEM     = 5'd0;
        hz.rd_WB      = 5'd0;
        #1;
        tests++;
        if (hz.forward_sel !== 4'b0000) begin fails++; $display("FAIL fwd_x0 got %b want 0000", hz.forward_sel); end
        clear_in();
    endtask

    task automatic test_load_use();
        step();
        clear_in();
        hz.mem_read_MEM = 1'b1;
        hz.reg_WB_MEM   = 1'b1;
        hz.rd_MEM       = 5'd7;
        hz.rs_ID        = {5'd7, 5'd0};
        hz.rs_used_ID   = 2'b10;
        #1;
        tests++;
        if (hz.stall !== 1'b1) begin fails++; $display("FAIL load_use got %b want 1", hz.stall); end
        hz.rs_used_ID = 2'b01;
        #1;
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL load_use_unused got %b want 0", hz.stall); end
        hz.rd_MEM     = 5'd0;
        hz.rs_ID      = '0;
        hz.rs_used_ID = 2'b11;
        #1;
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL load_use_x0 got %b want 0", hz.stall); end
        clear_in();
    endtask

    task automatic test_long();
        step();
        issue_long(5'd9);
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL long_accept_stall got %b want 0", hz.stall); end
        for (int c = 1; c <= 2; c++) begin
            step();
            clear_in();
            hz.rs_ID      = {5'd0, 5'd9};
            hz.rs_used_ID = 2'b01;
            #1;
            tests++;
            if (hz.stall !== 1'b1) begin fails++; $display("FAIL long_raw_T%0d got %b want 1", c, hz.stall); end
            tests++;
            if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL long_busy_wb_T%0d got %b want 0", c, hz.long_wb); end
        end
        tests++;
        if (hz.long_rd !== 5'd9) begin fails++; $display("FAIL long_rd got %0d want 9", hz.long_rd); end
        step();
        tests++;
        if (hz.long_wb !== 1'b1) begin fails++; $display("FAIL long_done_wb got %b want 1", hz.long_wb); end
        tests++;
        if (hz.forward_sel !== 4'b0011) begin fails++; $display("FAIL long_done_fwd got %b want 0011", hz.forward_sel); end
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL long_done_stall got %b want 0", hz.stall); end
        step();
        tests++;
        if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL long_idle_wb got %b want 0", hz.long_wb); end
        tests++;
        if (hz.forward_sel !== 4'b0000) begin fails++; $display("FAIL long_idle_fwd got %b want 0000", hz.forward_sel); end
        clear_in();
    endtask

    task automatic test_back_to_back();
        step();
        issue_long(5'd9);
        step();
        issue_long(5'd4);
        tests++;
        if (hz.stall !== 1'b1) begin fails++; $display("FAIL b2b_structural got %b want 1", hz.stall); end
        step();
        clear_in();
        hz.reg_WB_ID = 1'b1;
        hz.rd_ID     = 5'd9;
        #1;
        tests++;
        if (hz.stall !== 1'b1) begin fails++; $display("FAIL b2b_waw got %b want 1", hz.stall); end
        step();
        issue_long(5'd12);
        tests++;
        if (hz.long_wb !== 1'b1) begin fails++; $display("FAIL b2b_done_wb got %b want 1", hz.long_wb); end
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL b2b_done_issue_stall got %b want 0", hz.stall); end
        step();
        clear_in();
        #1;
        tests++;
        if (hz.long_rd !== 5'd12) begin fails++; $display("FAIL b2b_long_rd got %0d want 12", hz.long_rd); end
        tests++;
        if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL b2b_T4_wb got %b want 0", hz.long_wb); end
        step();
        tests++;
        if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL b2b_T5_wb got %b want 0", hz.long_wb); end
        step();
        tests++;
        if (hz.long_wb !== 1'b1) begin fails++; $display("FAIL b2b_T6_wb got %b want 1", hz.long_wb); end
        step();
        tests++;
        if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL b2b_T7_wb got %b want 0", hz.long_wb); end
    endtask

    task automatic test_flush();
        step();
        issue_long(5'd9);
        step();
        clear_in();
        hz.flush      = 1'b1;
        hz.long_issue = 1'b1;
        hz.rd_ID      = 5'd6;
        #1;
        tests++;
        if (hz.stall !== 1'b1) begin fails++; $display("FAIL flush_struct_stall got %b want 1", hz.stall); end
        step();
        clear_in();
        hz.rs_ID      = {5'd9, 5'd0};
        hz.rs_used_ID = 2'b10;
        #1;
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL flush_idle_stall got %b want 0", hz.stall); end
        for (int c = 2; c <= 4; c++) begin
            tests++;
            if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL flush_wb_T%0d got %b want 0", c, hz.long_wb); end
            step();
        end
        clear_in();
        hz.long_issue = 1'b1;
        hz.flush      = 1'b1;
        hz.rd_ID      = 5'd9;
        #1;
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL flush_issue_idle_stall got %b want 0", hz.stall); end
        for (int c = 1; c <= 3; c++) begin
            step();
            clear_in();
            #1;
            tests++;
            if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL flush_issue_wb_T%0d got %b want 0", c, hz.long_wb); end
        end
    endtask

    task automatic test_reset_mid_busy();
        step();
        issue_long(5'd9);
        step();
        clear_in();
        rst_n = 1'b0;
        hz.rs_ID      = {5'd0, 5'd9};
        hz.rs_used_ID = 2'b01;
        #1;
        tests++;
        if (hz.long_rd !== 5'd0) begin fails++; $display("FAIL rst_busy_long_rd got %0d want 0", hz.long_rd); end
        tests++;
        if (hz.stall !== 1'b0) begin fails++; $display("FAIL rst_busy_stall got %b want 0", hz.stall); end
        tests++;
        if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL rst_busy_wb got %b want 0", hz.long_wb); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            tests++;
            if (hz.long_wb !== 1'b0) begin fails++; $display("FAIL rst_after_wb_%0d got %b want 0", c, hz.long_wb); end
        end
        clear_in();
    endtask

`ifdef FWD_STATS_EN
    task automatic load_use_stall();
        hz.mem_read_MEM = 1'b1;
        hz.reg_WB_MEM   = 1'b1;
        hz.rd_MEM       = 5'd7;
        hz.rs_ID        = {5'd0, 5'd7};
        hz.rs_used_ID   = 2'b01;
    endtask

    task automatic test_stats();
        clear_in();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        load_use_stall();
        repeat (5) @(posedge clk);
        #1;
        clear_in();
        #1;
        tests++;
        if (stall_cnt !== 32'd5) begin fails++; $display("FAIL stats_count got %0d want 5", stall_cnt); end
        force dut.stall_cnt_q = 32'hFFFF_FFFD;
        step();
        release dut.stall_cnt_q;
        load_use_stall();
        repeat (4) @(posedge clk);
        #1;
        clear_in();
        #1;
        tests++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin fails++; $display("FAIL stats_saturate got %h want ffffffff", stall_cnt); end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        clear_in();
        test_reset();
        test_forward();
        test_load_use();
        test_long();
        test_back_to_back();
        test_flush();
        test_reset_mid_busy();
`ifdef FWD_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage RISC-V pipeline, sitting between ID/EX decode and the EX operand muxes. It generalises operand forwarding to NUM_RD source ports and fixes priority so the youngest producer wins. It adds load-use stall detection and a single-entry scoreboard tracking one outstanding multi-cycle (long-latency) operation. The scoreboard provides RAW/WAW stalls, a structural stall and a result-forward path for that operation.

## Interface
- NUM_RD, 2: number of source-operand ports checked.
- REG_AW, 5: register index width.
- LONG_LAT, 3: long-unit latency in cycles, ≥1.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs_ID  in  NUM_RD*REG_AW  packed source indices of the instruction in ID; port i occupies bits [i*REG_AW +: REG_AW].
- rs_used_ID  in  NUM_RD  port i is actually read.
- rd_ID  in  REG_AW  destination of the instruction in ID.
- reg_WB_ID  in  1  instruction in ID writes rd_ID.
- long_issue  in  1  instruction in ID is a long-unit op.
- rd_MEM, rd_WB  in  REG_AW  destinations in MEM and WB.
- reg_WB_MEM, reg_WB_WB  in  1  write enables in MEM and WB.
- mem_read_MEM  in  1  MEM-stage instruction is a load.
- flush  in  1  kill the pending long op.
- forward_sel  out  NUM_RD*2  per port: 00 regfile, 01 MEM, 10 WB, 11 long-unit result.
- stall  out  1  hold IF/ID; bubble into EX.
- long_wb  out  1  long-unit result writes back this cycle.
- long_rd  out  REG_AW  destination of the long op.
- stall_cnt  out  32  saturating stall-cycle count. Present only with FWD_STATS_EN.

## Operation
- Index 0 never matches anything. A port matches only when its rs_used_ID bit is set.
- Forward priority per port:
  - MEM (reg_WB_MEM, not a load) first.
  - Then long result (state DONE, rs == long_rd).
  - Then WB.
  - Otherwise 00.
- Load-use: port matches rd_MEM with reg_WB_MEM and mem_read_MEM → stall. forward_sel for that port is don't-care.
- Scoreboard states: IDLE, BUSY, DONE. A counter cnt of width $clog2(LONG_LAT+1) runs in BUSY.
- accept = long_issue & ~stall & ~flush.
- Transitions:
  - IDLE or DONE, with accept: capture long_rd ← rd_ID. Go to DONE if LONG_LAT==1; else BUSY with cnt = LONG_LAT-1.
  - IDLE, no accept: stay IDLE.
  - DONE, no accept: go to IDLE.
  - BUSY, cnt==1: go to DONE.
  - BUSY, otherwise: cnt decrements.
  - flush: go to IDLE from any state; overrides accept.
- long_wb = (state==DONE).
- Stall sources while BUSY:
  - RAW: a used port matches long_rd.
  - WAW: reg_WB_ID and rd_ID == long_rd, rd_ID ≠ 0.
  - Structural: long_issue asserted.
- In DONE none of these stall. RAW is satisfied by forward 11. A new long issue is accepted back-to-back.
- stall is the OR of load-use, RAW, WAW and structural.

## Timing
- forward_sel and stall are combinational from the current-cycle inputs and the registered state; zero latency.
- A long op accepted in cycle T asserts long_wb exactly in cycle T+LONG_LAT, for one cycle.
- Reset (async assert, sync release) gives:
  - state IDLE, cnt 0.
  - long_wb 0, long_rd 0, stall_cnt 0.
  - stall and forward_sel follow the inputs with an idle scoreboard.
- Reset or flush mid-BUSY: the op is dropped and long_wb is never raised for it.
- Simultaneous flush and long_issue: the issue is not accepted and stall is unaffected by flush.

## Configuration
- FWD_STATS_EN defined:
  - stall_cnt port and its register exist.
  - stall_cnt increments on every cycle with stall=1.
  - It saturates at 32'hFFFFFFFF and clears only on reset.
- FWD_STATS_EN undefined: port and logic absent; all other behaviour is identical.

## Test plan
- rs_ID={x5,x5}, rd_MEM=x5 ALU, rd_WB=x5 → forward_sel=01/01, stall=0. With rd_MEM=x0 instead → 10/10.
- Load in MEM with rd_MEM=x7, rs port1=x7 used → stall=1. Same with rs_used_ID[1]=0 → stall=0.
- LONG_LAT=3, accept at T with rd_ID=x9, then rs=x9 → stall=1 in T+1..T+2. At T+3: long_wb=1, forward_sel=11, stall=0. At T+4: IDLE.
- While BUSY: long_issue → stall=1. Issue in DONE cycle is accepted and long_wb is seen 3 cycles later; WAW with rd_ID=x9 and reg_WB_ID=1 stalls.
- flush at T+1 after accept → IDLE at T+2, long_wb stays 0. rst_n low mid-BUSY → all outputs reset immediately.
- FWD_STATS_EN: 5 stall cycles → stall_cnt=5. Preloaded near max → holds 32'hFFFFFFFF.
